whack_input_ctrl: RTL and testbench

- Player-input end of the mole display path. Samples the 10 raw hit buttons, then synchronizes, debounces and edge-detects them.
- Encodes each press into a hole index, 1..10, using the same numbering the LED decoder uses for Q.
- Judges each press against the active mole and runs the game FSM that drives the 2-bit `state` bus consumed by the LED decoder.
- Also keeps the score and requests new random moles from the random-number source.

---
 rtl/whack_input_ctrl_pkg.sv | 45 ++++
 rtl/whack_input_ctrl_btn_debounce.sv | 56 +++++
 rtl/whack_input_ctrl.sv | 154 +++++++++++++++
 tb/tb_whack_input_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/whack_input_ctrl_pkg.sv
// Shared definitions for the whack-a-mole input controller: game state codes
// (same encoding the LED decoder expects), hole count and press encoding.
package whack_input_ctrl_pkg;

    localparam int NUM_HOLES = 10;

    // Index reported when several holes are struck in the same cycle; never
    // matches a real mole, so it always judges as a miss.
    localparam logic [3:0] IDX_MULTI = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        POP  = 2'b01,
        HIT  = 2'b10,
        MISS = 2'b11
    } game_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } press_evt_t;

    // One-hot press vector -> hole event (bit k is hole k+1).
    function automatic press_evt_t encode_press(input logic [NUM_HOLES-1:0] press);
        press_evt_t evt;
        int         n;
        evt = '0;
        n   = 0;
        for (int k = 0; k < NUM_HOLES; k++) begin
            if (press[k]) begin
                n++;
                evt.idx = 4'(k + 1);
            end
        end
        if (n > 0) evt.valid = 1'b1;
        if (n > 1) evt.idx   = IDX_MULTI;
        return evt;
    endfunction

    // True when a random value names a real hole.
    function automatic logic hole_valid(input logic [3:0] h);
        return (h >= 4'd1) && (h <= 4'(NUM_HOLES));
    endfunction

endpackage

// File: rtl/whack_input_ctrl_btn_debounce.sv
// Single-button input conditioning: 2-flop synchronizer, debounce counter
// and rising-edge detect of the debounced level.
module whack_input_ctrl_btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          lvl_q, lvl_d;
    logic          lvl_prev_q, lvl_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the accepted level; flip after enough.
    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        lvl_d      = lvl_q;
        lvl_prev_d = lvl_q;
        cnt_d      = cnt_q;
        if (sync2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            lvl_d = ~lvl_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset is synchronous and active high.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_prev_d;
            cnt_q      <= cnt_d;
        end
    end

    assign press = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/whack_input_ctrl.sv
// Player-input end of the mole display path: conditions the 10 hit buttons,
// encodes presses to hole indices, judges them against the active mole and
// runs the game FSM, score and new-mole requests.
module whack_input_ctrl
    import whack_input_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 16,
    parameter int POP_CYCLES  = 50_000_000,
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_HOLES-1:0] btn,
    input  logic [5:0]           Q,
    input  logic                 start,
    input  logic                 stop,
    output logic [1:0]           state,
    output logic [3:0]           mole,
    output logic                 new_mole,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [7:0]           score
);

    localparam int PW = (POP_CYCLES > 1) ? $clog2(POP_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [NUM_HOLES-1:0] press;
    press_evt_t           evt;

    // Only the low nibble of Q selects a hole.
    logic unused_q_hi;
    assign unused_q_hi = ^Q[5:4];

    for (genvar k = 0; k < NUM_HOLES; k++) begin : g_btn
        whack_input_ctrl_btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn[k]),
            .press  (press[k])
        );
    end

    assign evt = encode_press(press);

    game_state_e   state_q, state_d;
    logic [3:0]    mole_q, mole_d;
    logic [7:0]    score_q, score_d;
    logic          new_mole_q, new_mole_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic          load_q, load_d;     // a pop load is attempted this cycle
    logic [PW-1:0] pop_tmr_q, pop_tmr_d;
    logic [HW-1:0] hold_tmr_q, hold_tmr_d;

    // Game FSM next state: stop overrides everything, then pending pop load, then per-state rules.
    always_comb begin
        state_d    = state_q;
        mole_d     = mole_q;
        score_d    = score_q;
        pop_tmr_d  = pop_tmr_q;
        hold_tmr_d = hold_tmr_q;
        load_d     = 1'b0;
        new_mole_d = 1'b0;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        if (stop) begin
            state_d    = IDLE;
            pop_tmr_d  = '0;
            hold_tmr_d = '0;
        end else if (load_q) begin
            if (hole_valid(Q[3:0])) begin
                mole_d    = Q[3:0];
                pop_tmr_d = '0;
                state_d   = POP;
            end else begin
                // Out-of-range random value: ask the generator again.
                new_mole_d = 1'b1;
                load_d     = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        score_d    = '0;
                        new_mole_d = 1'b1;
                        load_d     = 1'b1;
                    end
                end
                POP: begin
                    // A matching press beats a simultaneous timeout.
                    if (evt.valid && (evt.idx == mole_q)) begin
                        state_d    = HIT;
                        hit_d      = 1'b1;
                        hold_tmr_d = '0;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    end else if (evt.valid || (pop_tmr_q == PW'(POP_CYCLES - 1))) begin
                        state_d    = MISS;
                        miss_d     = 1'b1;
                        hold_tmr_d = '0;
                    end else begin
                        pop_tmr_d = pop_tmr_q + 1'b1;
                    end
                end
                HIT, MISS: begin
                    // Presses are dropped while the verdict is shown.
                    if (hold_tmr_q == HW'(HOLD_CYCLES - 1)) begin
                        hold_tmr_d = '0;
                        new_mole_d = 1'b1;
                        load_d     = 1'b1;
                    end else begin
                        hold_tmr_d = hold_tmr_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Game registers; reset is synchronous and active high and discards the game.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            mole_q     <= '0;
            score_q    <= '0;
            new_mole_q <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            load_q     <= 1'b0;
            pop_tmr_q  <= '0;
            hold_tmr_q <= '0;
        end else begin
            state_q    <= state_d;
            mole_q     <= mole_d;
            score_q    <= score_d;
            new_mole_q <= new_mole_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            load_q     <= load_d;
            pop_tmr_q  <= pop_tmr_d;
            hold_tmr_q <= hold_tmr_d;
        end
    end

    assign state      = state_q;
    assign mole       = mole_q;
    assign score      = score_q;
    assign new_mole   = new_mole_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;

endmodule

// File: tb/tb_whack_input_ctrl.sv
// Bench for whack_input_ctrl: directed game scenarios plus randomized rounds
// judged by a round-level model (press latency, timeout window, saturating score).
module tb_whack_input_ctrl;

    localparam int DEB  = 4;
    localparam int POP  = 20;
    localparam int HOLD = 8;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_POP  = 2'b01;
    localparam logic [1:0] S_HIT  = 2'b10;
    localparam logic [1:0] S_MISS = 2'b11;

    logic       clk;
    logic       rst_n;
    logic [9:0] btn;
    logic [5:0] Q;
    logic       start;
    logic       stop;
    logic [1:0] state;
    logic [3:0] mole;
    logic       new_mole;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [7:0] score;

    int         checks   = 0;
    int         failures = 0;
    int         exp_score;
    logic [3:0] cur_mole;

    whack_input_ctrl #(
        .DEB_CYCLES (DEB),
        .POP_CYCLES (POP),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .Q         (Q),
        .start     (start),
        .stop      (stop),
        .state     (state),
        .mole      (mole),
        .new_mole  (new_mole),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse),
        .score     (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One POP round, starting on the cycle right after the pop load. A press
    // driven at step d reaches the FSM DEB+3 steps later; it counts only if that
    // lands no later than the timeout step POP. The verdict is held HOLD cycles,
    // then new_mole, then a pop load of nq.
    task automatic run_round(input logic [9:0] bits, input int d, input bit toggle,
                             input logic [5:0] nq);
        bit         ev, hit;
        int         o, sd;
        logic [1:0] exp_st;
        logic [9:0] mole_bit;
        mole_bit = '0;
        mole_bit[cur_mole - 4'd1] = 1'b1;
        ev  = (bits != '0) && !toggle && (d + DEB + 3 <= POP);
        hit = ev && (bits == mole_bit);
        o   = ev ? d + DEB + 3 : POP;
        exp_st = hit ? S_HIT : S_MISS;
        if (hit && exp_score < 255) exp_score++;
        Q = nq;
        for (int s = 0; s < o + HOLD + 1; s++) begin
            if (toggle) begin
                btn = (s < POP && ((s / 2) % 2) == 0) ? bits : '0;
            end else begin
                if (s == d)      btn = bits;
                if (s == d + 10) btn = '0;
            end
            @(negedge clk);
            sd = s + 1;
            if (sd == o - 1) begin
                chk("pre_state", state, S_POP);
                chk("pre_pulses", {hit_pulse, miss_pulse}, 2'b00);
            end
            if (sd == o) begin
                chk("verdict_state", state, exp_st);
                chk("hit_pulse", hit_pulse, hit);
                chk("miss_pulse", miss_pulse, !hit);
                chk("score", score, exp_score);
            end
            if (sd == o + 1) chk("pulse_len", {hit_pulse, miss_pulse}, 2'b00);
            if (sd == o + HOLD) begin
                chk("hold_new_mole", new_mole, 1'b1);
                chk("hold_state", state, exp_st);
            end
            if (sd == o + HOLD + 1) begin
                chk("reload_state", state, S_POP);
                chk("reload_mole", mole, nq[3:0]);
                chk("reload_nm", new_mole, 1'b0);
            end
        end
        btn = '0;
        cur_mole = nq[3:0];
    endtask

    initial begin
        logic [9:0] bits;
        logic [5:0] nq;
        logic [3:0] hole;
        logic [1:0] hi;
        int         r, d, w, a, b;

        rst_n = 1'b1; btn = '0; Q = '0; start = 1'b0; stop = 1'b0;
        exp_score = 0; cur_mole = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, S_IDLE);
        chk("rst_mole", mole, 4'd0);
        chk("rst_score", score, 8'd0);
        chk("rst_pulses", {new_mole, hit_pulse, miss_pulse}, 3'b000);
        rst_n = 1'b0;
        @(negedge clk);
        chk("idle_hold", state, S_IDLE);

        // Start with a valid Q: one new_mole, then POP on the next cycle.
        Q = 6'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_nm", new_mole, 1'b1);
        chk("start_state", state, S_IDLE);
        @(negedge clk);
        chk("pop_state", state, S_POP);
        chk("pop_mole", mole, 4'd3);
        chk("pop_score", score, 8'd0);
        chk("pop_nm", new_mole, 1'b0);
        cur_mole = 4'd3;

        run_round(10'b00_0000_0100, 0, 1'b0, 6'd5);   // clean hit on hole 3
        run_round(10'b00_0001_0000, 0, 1'b1, 6'd3);   // bouncing button, timeout miss
        run_round(10'b00_0010_0000, 8, 1'b0, 6'd3);   // wrong hole
        run_round(10'b00_0001_0100, 8, 1'b0, 6'h33);  // two holes at once

        // stop mid-POP: IDLE next cycle, score and mole kept.
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_state", state, S_IDLE);
        chk("stop_mole", mole, 4'd3);
        chk("stop_score", score, exp_score);
        // start and stop together: stop wins, score not cleared.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("ss_state", state, S_IDLE);
        chk("ss_nm", new_mole, 1'b0);
        chk("ss_score", score, exp_score);

        // Pop load retries on Q=0 and Q=12, accepts Q=7.
        Q = 6'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_score = 0;
        chk("rs_nm0", new_mole, 1'b1);
        chk("rs_score", score, exp_score);
        @(negedge clk);
        chk("rs_nm1", new_mole, 1'b1);
        chk("rs_st1", state, S_IDLE);
        Q = 6'd12;
        @(negedge clk);
        chk("rs_nm2", new_mole, 1'b1);
        chk("rs_st2", state, S_IDLE);
        Q = 6'd7;
        @(negedge clk);
        chk("rs_state", state, S_POP);
        chk("rs_mole", mole, 4'd7);
        chk("rs_nm3", new_mole, 1'b0);
        cur_mole = 4'd7;

        // Randomized rounds.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            d = $urandom_range(8, 15);
            bits = '0;
            if (r < 5) begin
                bits[cur_mole - 4'd1] = 1'b1;
            end else if (r < 7) begin
                w = $urandom_range(1, 9);
                if (w >= int'(cur_mole)) w++;
                bits[w - 1] = 1'b1;
            end else if (r >= 8) begin
                a = $urandom_range(0, 9);
                b = $urandom_range(0, 8);
                if (b >= a) b++;
                bits[a] = 1'b1;
                bits[b] = 1'b1;
            end
            hole = 4'($urandom_range(1, 10));
            hi   = 2'($urandom_range(0, 3));
            nq   = {hi, hole};
            run_round(bits, d, 1'b0, nq);
        end

        // Drive the score to saturation, then two more hits.
        while (exp_score < 257 && !(exp_score == 255 && checks < 0)) begin
            bits = '0;
            bits[cur_mole - 4'd1] = 1'b1;
            hole = 4'($urandom_range(1, 10));
            nq   = {2'b00, hole};
            if (exp_score == 255) break;
            run_round(bits, 8, 1'b0, nq);
        end
        for (int i = 0; i < 2; i++) begin
            bits = '0;
            bits[cur_mole - 4'd1] = 1'b1;
            hole = 4'($urandom_range(1, 10));
            nq   = {2'b00, hole};
            run_round(bits, 8, 1'b0, nq);
        end
        chk("sat_score", score, 8'd255);

        // Reset mid-POP drops everything at once.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", state, S_IDLE);
        chk("mid_rst_mole", mole, 4'd0);
        chk("mid_rst_score", score, 8'd0);
        chk("mid_rst_pulses", {new_mole, hit_pulse, miss_pulse}, 3'b000);
        rst_n = 1'b0;
        @(negedge clk);
        chk("post_rst_state", state, S_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
